regfile_write_arbiter: RTL and testbench

Shares the register file's single write port between the ALU writeback path and the load/store unit writeback path, and keeps a per-register pending-write scoreboard so the issue stage can stall on RAW hazards. Sits between the execute/memory stages and the register file. It drives the register file's `writeEnable`/`writeAddr`/`writeData` from registered outputs.

---
 rtl/regfile_write_arbiter.sv | 122 ++++++++++++
 tb/tb_regfile_write_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// =============================================================================
// regfile_write_arbiter : shares the register file write port between ALU and
// LSU writeback and tracks pending writes per register for RAW stalls.
// Build option REGFILE_ARB_RR_EN: round-robin arbitration (else LSU priority).
// Revision: 1.0
// =============================================================================
module regfile_write_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [ADDR_W-1:0] lsu_rd,
  input  logic [DATA_W-1:0] lsu_data,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              writeEnable,
  output logic [ADDR_W-1:0] writeAddr,
  output logic [DATA_W-1:0] writeData
);

  localparam int NREG = 1 << ADDR_W;

  logic              w_lsu_wins;
  logic              w_alu_grant;
  logic              w_lsu_grant;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;

`ifdef REGFILE_ARB_RR_EN
  logic r_favor_lsu;

  assign w_lsu_wins = r_favor_lsu;

  // After any grant the other requester is favoured on the next conflict.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_favor_lsu <= 1'b0;
    end else if (w_alu_grant) begin
      r_favor_lsu <= 1'b1;
    end else if (w_lsu_grant) begin
      r_favor_lsu <= 1'b0;
    end
  end
`else
  assign w_lsu_wins = 1'b1;
`endif

  assign w_alu_grant = alu_valid && (!lsu_valid || !w_lsu_wins);
  assign w_lsu_grant = lsu_valid && (!alu_valid || w_lsu_wins);
  assign alu_ready   = w_alu_grant;
  assign lsu_ready   = w_lsu_grant;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else if (w_lsu_grant) begin
      r_we   <= (lsu_rd != '0);
      r_addr <= lsu_rd;
      r_data <= lsu_data;
    end else if (w_alu_grant) begin
      r_we   <= (alu_rd != '0);
      r_addr <= alu_rd;
      r_data <= alu_data;
    end else begin
      r_we   <= 1'b0;
    end
  end

  assign writeEnable = r_we;
  assign writeAddr   = r_addr;
  assign writeData   = r_data;

  // Entry 0 is a constant so x0 never reports busy.
  logic [1:0] w_cnt [NREG];
  assign w_cnt[0] = 2'd0;

  for (genvar r = 1; r < NREG; r++) begin : g_sb
    logic [1:0] r_cnt;
    logic       w_inc;
    logic       w_dec;

    assign w_inc = issue_valid && (issue_rd == ADDR_W'(r));
    assign w_dec = r_we && (r_addr == ADDR_W'(r));

    always_ff @(posedge clk) begin
      if (!reset) begin
        r_cnt <= 2'd0;
      end else if (w_inc && !w_dec && (r_cnt != 2'd3)) begin
        r_cnt <= r_cnt + 2'd1;
      end else if (w_dec && !w_inc && (r_cnt != 2'd0)) begin
        r_cnt <= r_cnt - 2'd1;
      end
    end

    assign w_cnt[r] = r_cnt;

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
      !(w_inc && !w_dec && (r_cnt == 2'd3)));
    a_no_underflow: assert property (@(posedge clk) disable iff (!reset)
      !(w_dec && !w_inc && (r_cnt == 2'd0)));
  end

  assign rs1_busy = (w_cnt[rs1_addr] != 2'd0) && (rs1_addr != '0);
  assign rs2_busy = (w_cnt[rs2_addr] != 2'd0) && (rs2_addr != '0);

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// =============================================================================
// tb_regfile_write_arbiter : directed self-checking bench for the write arbiter.
// Revision: 1.0
// =============================================================================
module tb_regfile_write_arbiter;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
`ifdef REGFILE_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              alu_valid, lsu_valid, issue_valid;
  logic              alu_ready, lsu_ready;
  logic [ADDR_W-1:0] alu_rd, lsu_rd, issue_rd, rs1_addr, rs2_addr;
  logic [DATA_W-1:0] alu_data, lsu_data;
  logic              rs1_busy, rs2_busy;
  logic              writeEnable;
  logic [ADDR_W-1:0] writeAddr;
  logic [DATA_W-1:0] writeData;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_write_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .lsu_valid  (lsu_valid),
    .lsu_ready  (lsu_ready),
    .lsu_rd     (lsu_rd),
    .lsu_data   (lsu_data),
    .issue_valid(issue_valid),
    .issue_rd   (issue_rd),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rs1_busy   (rs1_busy),
    .rs2_busy   (rs2_busy),
    .writeEnable(writeEnable),
    .writeAddr  (writeAddr),
    .writeData  (writeData)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic       exp_lsu;
    logic [4:0] exp_rd;

    reset       = 1'b0;
    alu_valid   = 1'b1;
    lsu_valid   = 1'b1;
    alu_rd      = 5'd1;
    lsu_rd      = 5'd2;
    alu_data    = 32'h1111_1111;
    lsu_data    = 32'h2222_2222;
    issue_valid = 1'b0;
    issue_rd    = 5'd0;
    rs1_addr    = 5'd1;
    rs2_addr    = 5'd2;

    // Reset with both requesters active
    tick();
    tick();
    check("rst_we",       writeEnable, 0);
    check("rst_addr",     writeAddr,   0);
    check("rst_data",     writeData,   0);
    check("rst_rs1_busy", rs1_busy,    0);
    check("rst_rs2_busy", rs2_busy,    0);
    check("rst_alu_rdy",  alu_ready,   RR ? 1 : 0);
    check("rst_lsu_rdy",  lsu_ready,   RR ? 0 : 1);
    reset = 1'b1;

    // Four-cycle conflict; issue the granted rd so the scoreboard stays balanced
    for (int i = 0; i < 4; i++) begin
      exp_lsu     = RR ? ((i % 2) == 1) : 1'b1;
      exp_rd      = exp_lsu ? 5'd2 : 5'd1;
      issue_valid = 1'b1;
      issue_rd    = exp_rd;
      #1;
      check($sformatf("cf%0d_alu_rdy", i), alu_ready, !exp_lsu);
      check($sformatf("cf%0d_lsu_rdy", i), lsu_ready, exp_lsu);
      tick();
      check($sformatf("cf%0d_we", i),   writeEnable, 1);
      check($sformatf("cf%0d_addr", i), writeAddr,   exp_rd);
      check($sformatf("cf%0d_data", i), writeData,   exp_lsu ? 32'h2222_2222 : 32'h1111_1111);
    end
    alu_valid   = 1'b0;
    lsu_valid   = 1'b0;
    issue_valid = 1'b0;
    rs1_addr    = 5'd2;
    #1;
    check("cf_pend_busy", rs1_busy, 1);
    tick();
    check("cf_done_busy", rs1_busy, 0);

    // ALU-only write
    alu_valid   = 1'b1;
    alu_rd      = 5'd5;
    alu_data    = 32'hDEAD_BEEF;
    issue_valid = 1'b1;
    issue_rd    = 5'd5;
    #1;
    check("alu_only_rdy",     alu_ready, 1);
    check("alu_only_lsu_rdy", lsu_ready, 0);
    tick();
    alu_valid   = 1'b0;
    issue_valid = 1'b0;
    check("alu_we",   writeEnable, 1);
    check("alu_addr", writeAddr,   5);
    check("alu_data", writeData,   32'hDEAD_BEEF);
    tick();
    check("alu_we_off",    writeEnable, 0);
    check("alu_addr_hold", writeAddr,   5);
    check("alu_data_hold", writeData,   32'hDEAD_BEEF);

    // LSU-only write
    lsu_valid   = 1'b1;
    lsu_rd      = 5'd3;
    lsu_data    = 32'h0BAD_F00D;
    issue_valid = 1'b1;
    issue_rd    = 5'd3;
    #1;
    check("lsu_only_rdy",     lsu_ready, 1);
    check("lsu_only_alu_rdy", alu_ready, 0);
    tick();
    lsu_valid   = 1'b0;
    issue_valid = 1'b0;
    check("lsu_addr", writeAddr, 3);
    check("lsu_data", writeData, 32'h0BAD_F00D);
    tick();

    // Scoreboard: two issues to r7, two commits
    rs1_addr    = 5'd7;
    rs2_addr    = 5'd7;
    issue_valid = 1'b1;
    issue_rd    = 5'd7;
    #1;
    check("r7_same_cycle", rs1_busy, 0);
    tick();
    check("r7_busy_1", rs1_busy, 1);
    tick();
    issue_valid = 1'b0;
    alu_valid   = 1'b1;
    alu_rd      = 5'd7;
    alu_data    = 32'h0000_0007;
    tick();
    alu_valid = 1'b0;
    tick();
    check("r7_after_c1", rs2_busy, 1);
    alu_valid = 1'b1;
    tick();
    alu_valid = 1'b0;
    check("r7_strobe_c2", rs1_busy, 1);
    tick();
    check("r7_rs1_clear", rs1_busy, 0);
    check("r7_rs2_clear", rs2_busy, 0);

    // Simultaneous issue and commit of r9 at cnt=1
    rs1_addr    = 5'd9;
    issue_valid = 1'b1;
    issue_rd    = 5'd9;
    tick();
    issue_valid = 1'b0;
    alu_valid   = 1'b1;
    alu_rd      = 5'd9;
    tick();
    alu_valid   = 1'b0;
    issue_valid = 1'b1;
    tick();
    issue_valid = 1'b0;
    check("r9_same_edge", rs1_busy, 1);
    tick();
    check("r9_still", rs1_busy, 1);
    alu_valid = 1'b1;
    tick();
    alu_valid = 1'b0;
    tick();
    check("r9_clear", rs1_busy, 0);

    // rd = 0 is granted but never written or tracked
    alu_valid = 1'b1;
    alu_rd    = 5'd0;
    alu_data  = 32'h0000_0055;
    #1;
    check("x0_rdy", alu_ready, 1);
    tick();
    alu_valid = 1'b0;
    check("x0_we",   writeEnable, 0);
    check("x0_addr", writeAddr,   0);
    issue_valid = 1'b1;
    issue_rd    = 5'd0;
    rs1_addr    = 5'd0;
    tick();
    issue_valid = 1'b0;
    check("x0_busy", rs1_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
